// File: rtl/axi4lite_master_engine.sv
// axi4lite_master_engine
//   Command-driven AXI4-Lite master. Accepts one read or write command at a
//   time, runs the matching AXI4-Lite transaction and returns the response
//   code, read data and a saturating latency count. Single outstanding
//   transaction, no reordering, no timeout.
//
// Ports
//   A_CLK, A_RST                        clock, asynchronous active-high reset
//   CMD_VALID/READY/WRITE/ADDR/DATA     command port (valid/ready)
//   RSP_VALID/READY/WRITE/DATA/RESP/CYCLES  response port (valid/ready)
//   AW_*, W_*, B_*, AR_*, R_*           AXI4-Lite master channels
module axi4lite_master_engine #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32,
  parameter int LAT_WIDTH  = 16
) (
  input  logic                  A_CLK,
  input  logic                  A_RST,
  input  logic                  CMD_VALID,
  output logic                  CMD_READY,
  input  logic                  CMD_WRITE,
  input  logic [ADDR_WIDTH-1:0] CMD_ADDR,
  input  logic [DATA_WIDTH-1:0] CMD_DATA,
  output logic                  RSP_VALID,
  input  logic                  RSP_READY,
  output logic                  RSP_WRITE,
  output logic [DATA_WIDTH-1:0] RSP_DATA,
  output logic [1:0]            RSP_RESP,
  output logic [LAT_WIDTH-1:0]  RSP_CYCLES,
  output logic                  AW_VALID,
  input  logic                  AW_READY,
  output logic [ADDR_WIDTH-1:0] AW_ADDR,
  output logic                  W_VALID,
  input  logic                  W_READY,
  output logic [DATA_WIDTH-1:0] W_DATA,
  input  logic                  B_VALID,
  output logic                  B_READY,
  input  logic [1:0]            B_RESP,
  output logic                  AR_VALID,
  input  logic                  AR_READY,
  output logic [ADDR_WIDTH-1:0] AR_ADDR,
  input  logic                  R_VALID,
  output logic                  R_READY,
  input  logic [DATA_WIDTH-1:0] R_DATA,
  input  logic [1:0]            R_RESP
);

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    WR_AW_W = 3'd1,
    WR_B    = 3'd2,
    RD_AR   = 3'd3,
    RD_R    = 3'd4,
    RESP    = 3'd5
  } state_t;

  state_t state, state_next;
  logic   aw_done, w_done;
  logic   aw_done_next, w_done_next;

  logic cmd_fire, aw_fire, w_fire, b_fire, ar_fire, r_fire, rsp_fire;
  logic busy;

  assign cmd_fire = CMD_VALID & CMD_READY;
  assign aw_fire  = AW_VALID & AW_READY;
  assign w_fire   = W_VALID & W_READY;
  assign b_fire   = B_VALID & B_READY;
  assign ar_fire  = AR_VALID & AR_READY;
  assign r_fire   = R_VALID & R_READY;
  assign rsp_fire = RSP_VALID & RSP_READY;

  // Latency counts every cycle spent waiting on the slave; IDLE and RESP
  // are excluded so the count freezes while the response is pending.
  assign busy = (state == WR_AW_W) || (state == WR_B) ||
                (state == RD_AR)   || (state == RD_R);

  function automatic logic [LAT_WIDTH-1:0] sat_inc(input logic [LAT_WIDTH-1:0] v);
    return (&v) ? v : v + LAT_WIDTH'(1);
  endfunction

  always_ff @(posedge A_CLK or posedge A_RST) begin
    if (A_RST) begin
      state   <= IDLE;
      aw_done <= 1'b0;
      w_done  <= 1'b0;
    end else begin
      state   <= state_next;
      aw_done <= aw_done_next;
      w_done  <= w_done_next;
    end
  end

  always_comb begin
    state_next   = state;
    aw_done_next = aw_done;
    w_done_next  = w_done;
    case (state)
      IDLE: begin
        if (cmd_fire) begin
          aw_done_next = 1'b0;
          w_done_next  = 1'b0;
          state_next   = CMD_WRITE ? WR_AW_W : RD_AR;
        end
      end
      WR_AW_W: begin
        // AW and W finish independently, in either order or together.
        if (aw_fire) aw_done_next = 1'b1;
        if (w_fire)  w_done_next  = 1'b1;
        if (aw_done_next && w_done_next) state_next = WR_B;
      end
      WR_B:    if (b_fire)   state_next = RESP;
      RD_AR:   if (ar_fire)  state_next = RD_R;
      RD_R:    if (r_fire)   state_next = RESP;
      RESP:    if (rsp_fire) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // All interface outputs are registered from the next state, so each
  // VALID/READY changes exactly one cycle after the event that causes it.
  always_ff @(posedge A_CLK or posedge A_RST) begin
    if (A_RST) begin
      CMD_READY  <= 1'b1;
      AW_VALID   <= 1'b0;
      W_VALID    <= 1'b0;
      AR_VALID   <= 1'b0;
      B_READY    <= 1'b0;
      R_READY    <= 1'b0;
      RSP_VALID  <= 1'b0;
      AW_ADDR    <= '0;
      W_DATA     <= '0;
      AR_ADDR    <= '0;
      RSP_WRITE  <= 1'b0;
      RSP_DATA   <= '0;
      RSP_RESP   <= '0;
      RSP_CYCLES <= '0;
    end else begin
      CMD_READY <= (state_next == IDLE);
      AW_VALID  <= (state_next == WR_AW_W) && !aw_done_next;
      W_VALID   <= (state_next == WR_AW_W) && !w_done_next;
      AR_VALID  <= (state_next == RD_AR);
      B_READY   <= (state_next == WR_B);
      R_READY   <= (state_next == RD_R);
      RSP_VALID <= (state_next == RESP);

      if (cmd_fire) begin
        RSP_WRITE  <= CMD_WRITE;
        RSP_CYCLES <= '0;
        if (CMD_WRITE) begin
          AW_ADDR <= CMD_ADDR;
          W_DATA  <= CMD_DATA;
        end else begin
          AR_ADDR <= CMD_ADDR;
        end
      end else if (busy) begin
        RSP_CYCLES <= sat_inc(RSP_CYCLES);
      end

      if (b_fire) begin
        RSP_RESP <= B_RESP;
        RSP_DATA <= '0;
      end
      if (r_fire) begin
        RSP_RESP <= R_RESP;
        RSP_DATA <= R_DATA;
      end
    end
  end

endmodule
